// File: rtl/pcc_host.sv
// PC Card (PCMCIA) 8-bit host cycle engine: sequences setup/strobe/hold on the card bus.
// Optional WAIT timeout is enabled by defining PCC_HOST_TIMEOUT_EN.
module pcc_host #(
   parameter int SETUP_CYC   = 3,
   parameter int STROBE_CYC  = 8,
   parameter int HOLD_CYC    = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_space,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_timeout,
   output logic        rsp_inpack,
   output logic [15:0] A,
   input  logic [7:0]  D_IN,
   output logic [7:0]  D_OUT,
   output logic        DDIR,
   output logic        CE1,
   output logic        CE2,
   output logic        REG,
   output logic        OE,
   output logic        WE,
   output logic        IORD,
   output logic        IOWR,
   input  logic        WAIT,
   input  logic        INPACK
);

`ifdef PCC_HOST_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   localparam int CMAX = (SETUP_CYC > STROBE_CYC) ?
                         ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                         ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
   localparam int CW = $clog2(CMAX + 1);
   localparam int EW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [EW-1:0] ext;
   logic          armed;
   logic          write_q;
   logic [1:0]    space_q;
   logic [15:0]   addr_q;
   logic [7:0]    wdata_q;
   logic [1:0]    wait_sy, inpack_sy;
   logic          wait_s, inpack_s;
   logic          hs, min_met, to_hit, done;
   logic          active, strobe_on, is_io, reserved;

   assign wait_s   = wait_sy[1];
   assign inpack_s = inpack_sy[1];

   always_comb begin
      state_nx  = state;
      done      = 1'b0;
      reserved  = (space_q == 2'b11);
      is_io     = (space_q == 2'b10);
      req_ready = armed && (state == IDLE);
      hs        = req_valid && req_ready;
      min_met   = (cnt == CW'(STROBE_CYC - 1));
      to_hit    = TO_EN && (ext == EW'(TIMEOUT_CYC));
      case (state)
         IDLE:   if (hs) state_nx = SETUP;
         // A reserved-space request spends one SETUP clock without touching the bus.
         SETUP:  if (reserved) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                 end else if (cnt == CW'(SETUP_CYC - 1)) begin
                    state_nx = STROBE;
                 end
         STROBE: if (min_met && (wait_s || to_hit)) state_nx = HOLD;
         HOLD:   if (cnt == CW'(HOLD_CYC - 1)) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                 end
         default: state_nx = IDLE;
      endcase

      active    = (state != IDLE) && !reserved;
      strobe_on = (state == STROBE) && !reserved;
      CE1       = !active;
      CE2       = 1'b1;
      REG       = !(active && (space_q == 2'b01 || is_io));
      A         = active ? addr_q : '0;
      DDIR      = active && write_q;
      D_OUT     = DDIR ? wdata_q : '0;
      OE        = !(strobe_on && !is_io && !write_q);
      WE        = !(strobe_on && !is_io &&  write_q);
      IORD      = !(strobe_on &&  is_io && !write_q);
      IOWR      = !(strobe_on &&  is_io &&  write_q);
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state       <= IDLE;
         cnt         <= '0;
         ext         <= '0;
         armed       <= 1'b0;
         write_q     <= 1'b0;
         space_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wait_sy     <= '1;
         inpack_sy   <= '1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
         rsp_inpack  <= 1'b0;
      end else begin
         armed     <= 1'b1;
         wait_sy   <= {wait_sy[0], WAIT};
         inpack_sy <= {inpack_sy[0], INPACK};
         state     <= state_nx;
         rsp_valid <= done;

         // Counter saturates once the minimum strobe width is met; WAIT extension is tracked by ext.
         if (state_nx != state)
            cnt <= '0;
         else if (!(state == STROBE && min_met))
            cnt <= cnt + 1'b1;

         if (state != STROBE)
            ext <= '0;
         else if (TO_EN && min_met && !wait_s && !to_hit)
            ext <= ext + 1'b1;

         if (hs) begin
            write_q     <= req_write;
            space_q     <= req_space;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            rsp_inpack  <= 1'b0;
         end

         if (state == SETUP && reserved)
            rsp_timeout <= 1'b1;

         if (state == STROBE && is_io && !write_q && !inpack_s)
            rsp_inpack <= 1'b1;

         if (state == STROBE && state_nx == HOLD) begin
            if (to_hit) begin
               rsp_rdata   <= 8'hFF;
               rsp_timeout <= 1'b1;
            end else begin
               rsp_rdata   <= write_q ? 8'h00 : D_IN;
            end
         end
      end
   end

endmodule

// File: tb/tb_pcc_host.sv
// Self-checking bench for pcc_host: scoreboarded responses plus bus-timing measurements.
// Define PCC_HOST_TIMEOUT_EN to exercise the WAIT timeout path.
module tb_pcc_host;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_space = 2'b00;
   logic [15:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_timeout;
   logic        rsp_inpack;
   logic [15:0] A;
   logic [7:0]  D_IN = '0;
   logic [7:0]  D_OUT;
   logic        DDIR;
   logic        CE1, CE2, REG, OE, WE, IORD, IOWR;
   logic        WAIT = 1'b1;
   logic        INPACK = 1'b1;

   int          checks = 0;
   int          errors = 0;
   logic        started = 1'b0;
   logic [9:0]  sb[$];

   pcc_host #(
      .SETUP_CYC  (3),
      .STROBE_CYC (8),
      .HOLD_CYC   (2),
      .TIMEOUT_CYC(16)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_space  (req_space),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_timeout(rsp_timeout),
      .rsp_inpack (rsp_inpack),
      .A          (A),
      .D_IN       (D_IN),
      .D_OUT      (D_OUT),
      .DDIR       (DDIR),
      .CE1        (CE1),
      .CE2        (CE2),
      .REG        (REG),
      .OE         (OE),
      .WE         (WE),
      .IORD       (IORD),
      .IOWR       (IOWR),
      .WAIT       (WAIT),
      .INPACK     (INPACK)
   );

   always #5 CLK = ~CLK;

   // Strobes are mutually exclusive and never active while the card is deselected.
   always @(negedge CLK) begin
      if (started) begin
         checks++;
         if ($countones({OE, WE, IORD, IOWR}) < 3 || (CE1 && {OE, WE, IORD, IOWR} !== 4'hF)) begin
            errors++;
            $display("FAIL strobe_excl: OE=%b WE=%b IORD=%b IOWR=%b CE1=%b, required <=1 strobe low and none with CE1=1",
                     OE, WE, IORD, IOWR, CE1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   // Call at a negedge; returns just after the handshake edge.
   task automatic do_req(input logic w, input logic [1:0] sp, input logic [15:0] ad, input logic [7:0] wd);
      req_write = w;
      req_space = sp;
      req_addr  = ad;
      req_wdata = wd;
      req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (req_ready) break;
         @(negedge CLK);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_bound: got %b, required 1 within 20 clocks", req_ready);
      end
      @(posedge CLK);
      #1 req_valid = 1'b0;
   endtask

   // Samples each negedge until rsp_valid; pull/rel shape WAIT relative to strobe clocks.
   task automatic measure(input logic pull, input int rel, input logic [15:0] ea, input logic [7:0] ed,
                          input logic eddir, input logic ereg,
                          output int n, output int slow, output int setup, output int cel,
                          output int busbad, output logic [3:0] smask, output logic got, output logic [9:0] r);
      n = 0; slow = 0; setup = 0; cel = 0; busbad = 0; smask = '0; got = 1'b0; r = '0;
      for (int i = 0; i < 80; i++) begin
         @(negedge CLK);
         n++;
         if (!CE1) begin
            cel++;
            if (A !== ea || D_OUT !== ed || DDIR !== eddir || REG !== ereg) busbad++;
            if (slow == 0 && {OE, WE, IORD, IOWR} === 4'hF) setup++;
         end
         smask = smask | ~{OE, WE, IORD, IOWR};
         if ({OE, WE, IORD, IOWR} !== 4'hF) begin
            if (slow == 0 && pull) WAIT = 1'b0;
            if (slow == rel) WAIT = 1'b1;
            slow++;
         end
         if (rsp_valid) begin
            got = 1'b1;
            r = {rsp_rdata, rsp_timeout, rsp_inpack};
            break;
         end
      end
   endtask

   task automatic check_cycle(input string nm, input int n, input int en, input int slow, input int es,
                              input logic [3:0] smask, input logic [3:0] esm, input logic got, input logic [9:0] r);
      logic [9:0] exp_r;
      checks++;
      if (got !== 1'b1) begin
         errors++;
         $display("FAIL %s_rsp_bound: no rsp_valid within 80 clocks", nm);
      end
      checks++;
      if (n !== en) begin errors++; $display("FAIL %s_latency: got %0d, required %0d", nm, n, en); end
      checks++;
      if (slow !== es) begin errors++; $display("FAIL %s_strobe_len: got %0d, required %0d", nm, slow, es); end
      checks++;
      if (smask !== esm) begin errors++; $display("FAIL %s_strobe_sel: got %b, required %b", nm, smask, esm); end
      exp_r = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
      checks++;
      if (r !== exp_r) begin
         errors++;
         $display("FAIL %s_rsp: got rdata=%h to=%b ip=%b, required rdata=%h to=%b ip=%b",
                  nm, r[9:2], r[1], r[0], exp_r[9:2], exp_r[1], exp_r[0]);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      repeat (3) @(posedge CLK);
      started = 1'b1;
      @(negedge CLK);
      checks++;
      if ({CE1, CE2, REG, OE, WE, IORD, IOWR} !== 7'h7F) begin
         errors++; $display("FAIL reset_ctl: got %b, required 1111111", {CE1, CE2, REG, OE, WE, IORD, IOWR});
      end
      checks++;
      if ({DDIR, A, D_OUT} !== 25'h0) begin
         errors++; $display("FAIL reset_bus: got DDIR=%b A=%h D_OUT=%h, required all 0", DDIR, A, D_OUT);
      end
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_timeout, rsp_inpack} !== 12'h0) begin
         errors++; $display("FAIL reset_hs: got ready=%b valid=%b rdata=%h to=%b ip=%b, required all 0",
                            req_ready, rsp_valid, rsp_rdata, rsp_timeout, rsp_inpack);
      end
      RESET = 1'b1;
      @(negedge CLK);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", req_ready); end
   endtask

   task automatic test_mem_write();
      int n, slow, setup, cel, busbad; logic [3:0] sm; logic got; logic [9:0] r;
      WAIT = 1'b1; INPACK = 1'b1;
      sb.push_back({8'h00, 1'b0, 1'b0});
      do_req(1'b1, 2'b00, 16'h0123, 8'hA5);
      measure(1'b0, -1, 16'h0123, 8'hA5, 1'b1, 1'b1, n, slow, setup, cel, busbad, sm, got, r);
      check_cycle("mem_wr", n, 14, slow, 8, sm, 4'b0100, got, r);
      checks++;
      if (setup !== 3) begin errors++; $display("FAIL mem_wr_setup: got %0d, required 3", setup); end
      checks++;
      if (cel !== 13) begin errors++; $display("FAIL mem_wr_ce_span: got %0d, required 13", cel); end
      checks++;
      if (busbad !== 0) begin errors++; $display("FAIL mem_wr_bus: got %0d bad clocks, required 0", busbad); end
   endtask

   task automatic test_attr_read();
      int n, slow, setup, cel, busbad; logic [3:0] sm; logic got; logic [9:0] r;
      WAIT = 1'b1; INPACK = 1'b0; D_IN = 8'h41;
      sb.push_back({8'h41, 1'b0, 1'b0});
      do_req(1'b0, 2'b01, 16'h0000, 8'hEE);
      measure(1'b0, -1, 16'h0000, 8'h00, 1'b0, 1'b0, n, slow, setup, cel, busbad, sm, got, r);
      check_cycle("attr_rd", n, 14, slow, 8, sm, 4'b1000, got, r);
      checks++;
      if (busbad !== 0) begin errors++; $display("FAIL attr_rd_bus: got %0d bad clocks, required 0", busbad); end
   endtask

   task automatic test_io_read();
      int n, slow, setup, cel, busbad; logic [3:0] sm; logic got; logic [9:0] r;
      WAIT = 1'b1; INPACK = 1'b0; D_IN = 8'h3C;
      sb.push_back({8'h3C, 1'b0, 1'b1});
      do_req(1'b0, 2'b10, 16'h01F7, 8'h00);
      measure(1'b1, 20, 16'h01F7, 8'h00, 1'b0, 1'b0, n, slow, setup, cel, busbad, sm, got, r);
      check_cycle("io_rd_wait", n, 29, slow, 23, sm, 4'b0010, got, r);
      WAIT = 1'b1; INPACK = 1'b1; D_IN = 8'hC3;
      sb.push_back({8'hC3, 1'b0, 1'b0});
      do_req(1'b0, 2'b10, 16'h01F7, 8'h00);
      measure(1'b0, -1, 16'h01F7, 8'h00, 1'b0, 1'b0, n, slow, setup, cel, busbad, sm, got, r);
      check_cycle("io_rd_plain", n, 14, slow, 8, sm, 4'b0010, got, r);
   endtask

   task automatic test_io_write_wait();
      int n, slow, setup, cel, busbad; logic [3:0] sm; logic got; logic [9:0] r;
      INPACK = 1'b0; WAIT = 1'b0;
`ifdef PCC_HOST_TIMEOUT_EN
      sb.push_back({8'hFF, 1'b1, 1'b0});
      do_req(1'b1, 2'b10, 16'h0300, 8'h99);
      measure(1'b0, -1, 16'h0300, 8'h99, 1'b1, 1'b0, n, slow, setup, cel, busbad, sm, got, r);
      check_cycle("io_wr_timeout", n, 30, slow, 24, sm, 4'b0001, got, r);
`else
      sb.push_back({8'h00, 1'b0, 1'b0});
      do_req(1'b1, 2'b10, 16'h0300, 8'h99);
      measure(1'b0, 30, 16'h0300, 8'h99, 1'b1, 1'b0, n, slow, setup, cel, busbad, sm, got, r);
      check_cycle("io_wr_wait", n, 39, slow, 33, sm, 4'b0001, got, r);
`endif
      checks++;
      if (busbad !== 0) begin errors++; $display("FAIL io_wr_bus: got %0d bad clocks, required 0", busbad); end
      WAIT = 1'b1; INPACK = 1'b1;
   endtask

   task automatic test_reserved();
      int n, slow, setup, cel, busbad; logic [3:0] sm; logic got; logic [9:0] r;
      sb.push_back({8'h00, 1'b1, 1'b0});
      do_req(1'b0, 2'b11, 16'h1234, 8'h55);
      measure(1'b0, -1, 16'h0000, 8'h00, 1'b0, 1'b1, n, slow, setup, cel, busbad, sm, got, r);
      check_cycle("reserved", n, 2, slow, 0, sm, 4'b0000, got, r);
      checks++;
      if (cel !== 0) begin errors++; $display("FAIL reserved_ce: got %0d CE1-low clocks, required 0", cel); end
   endtask

   task automatic test_reset_mid();
      int n, slow, setup, cel, busbad, seen, vcount; logic [3:0] sm; logic got; logic [9:0] r;
      WAIT = 1'b1; D_IN = 8'h11;
      seen = 0; vcount = 0;
      do_req(1'b0, 2'b00, 16'h0456, 8'h00);
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (OE === 1'b0) seen++;
         if (seen == 3) break;
      end
      checks++;
      if (seen !== 3) begin errors++; $display("FAIL rst_mid_reach: got %0d strobe clocks, required 3", seen); end
      RESET = 1'b0;
      @(negedge CLK);
      checks++;
      if ({CE1, OE, WE, IORD, IOWR, rsp_valid, req_ready} !== 7'b1111100) begin
         errors++;
         $display("FAIL rst_mid_abort: got CE1/OE/WE/IORD/IOWR/valid/ready=%b, required 1111100",
                  {CE1, OE, WE, IORD, IOWR, rsp_valid, req_ready});
      end
      RESET = 1'b1;
      @(negedge CLK);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b, required 1", req_ready); end
      for (int i = 0; i < 16; i++) begin
         if (rsp_valid === 1'b1) vcount++;
         @(negedge CLK);
      end
      checks++;
      if (vcount !== 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d rsp_valid pulses, required 0", vcount); end
      D_IN = 8'h22;
      sb.push_back({8'h22, 1'b0, 1'b0});
      do_req(1'b0, 2'b00, 16'h0457, 8'h00);
      measure(1'b0, -1, 16'h0457, 8'h00, 1'b0, 1'b1, n, slow, setup, cel, busbad, sm, got, r);
      check_cycle("rst_mid_after", n, 14, slow, 8, sm, 4'b1000, got, r);
   endtask

   task automatic test_back_to_back();
      int hs, phase, got, rises, falls;
      logic prev_ce1;
      logic [9:0] exp_r;
      hs = 0; phase = 0; got = 0; rises = 0; falls = 0; prev_ce1 = 1'b1;
      WAIT = 1'b1; D_IN = 8'h77;
      req_write = 1'b1; req_space = 2'b00; req_addr = 16'h0200; req_wdata = 8'h5A;
      req_valid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (hs == 1 && phase == 0) begin
            req_write = 1'b0; req_addr = 16'h0300; phase = 1;
         end
         if (hs == 2 && phase == 1) begin
            req_valid = 1'b0; phase = 2;
         end
         if (req_valid && req_ready) begin
            sb.push_back((hs == 0) ? {8'h00, 1'b0, 1'b0} : {8'h77, 1'b0, 1'b0});
            hs++;
         end
         @(negedge CLK);
         if (prev_ce1 && !CE1) falls++;
         if (!prev_ce1 && CE1) rises++;
         prev_ce1 = CE1;
         if (rsp_valid) begin
            exp_r = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            checks++;
            if ({rsp_rdata, rsp_timeout, rsp_inpack} !== exp_r) begin
               errors++;
               $display("FAIL b2b_rsp%0d: got %h, required %h", got, {rsp_rdata, rsp_timeout, rsp_inpack}, exp_r);
            end
            got++;
            if (got == 2) break;
         end
      end
      req_valid = 1'b0;
      checks++;
      if (got !== 2) begin errors++; $display("FAIL b2b_count: got %0d responses, required 2", got); end
      checks++;
      if (hs !== 2) begin errors++; $display("FAIL b2b_handshakes: got %0d, required 2", hs); end
      checks++;
      if (rises !== 2 || falls !== 2) begin
         errors++; $display("FAIL b2b_idle_gap: got %0d CE1 rises / %0d falls, required 2/2", rises, falls);
      end
   endtask

   initial begin
      test_reset();
      test_mem_write();
      test_attr_read();
      test_io_read();
      test_io_write_wait();
      test_reserved();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pcc_host.md
PCC_HOST -- requirements
Module: pcc_host

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 3: clocks from address/CE valid to strobe assert (min 1).
REQ-002 SHALL have parameter STROBE_CYC, default 8: minimum clocks the strobe is held asserted (min 2).
REQ-003 SHALL have parameter HOLD_CYC, default 2: clocks address/CE/data are held after strobe deassert (min 1).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024: maximum clocks spent waiting on WAIT.
REQ-005 SHALL have port CLK, input, 1, single clock for all logic.
REQ-006 SHALL have port RESET, input, 1, synchronous active-low reset.
REQ-007 SHALL have port req_valid/req_ready, input/output, 1/1, request handshake; the transfer occurs on a cycle where both are high.
REQ-008 SHALL have port req_write, input, 1, 1 = write cycle, 0 = read cycle.
REQ-009 SHALL have port req_space, input, 2, 00 common memory, 01 attribute memory, 10 I/O, 11 reserved.
REQ-010 SHALL have port req_addr/req_wdata, input, 16/8, cycle address and write data.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle pulse at cycle end.
REQ-012 SHALL have ports rsp_rdata (output, 8), rsp_timeout (output, 1) and rsp_inpack (output, 1), all valid with rsp_valid.
REQ-013 SHALL have port A, output, 16, card address.
REQ-014 SHALL have ports D_IN (input, 8), D_OUT (output, 8) and DDIR (output, 1), card data bus; DDIR = 1 means the host drives.
REQ-015 SHALL have ports CE1, CE2, REG, OE, WE, IORD, IOWR, each output, 1, active-low card strobes.
REQ-016 SHALL have ports WAIT (input, 1) and INPACK (input, 1), active-low card responses.

Function
REQ-017 SHALL implement the states IDLE, SETUP, STROBE, HOLD and operate in 8-bit mode only: CE1 = 0 and CE2 = 1 during a cycle; both are 1 in IDLE.
REQ-018 SHALL assert req_ready only in IDLE; a handshake registers all req_* fields and enters SETUP on the next clock.
REQ-019 SHALL drive A, REG (0 for attribute memory and I/O) and CE1 from SETUP entry through the end of HOLD; for a write, D_OUT is valid and DDIR = 1 over the same span.
REQ-020 SHALL stay in SETUP for SETUP_CYC clocks, then enter STROBE.
REQ-021 SHALL assert exactly one strobe in STROBE: OE for memory reads, WE for memory writes, IORD for I/O reads, IOWR for I/O writes.
REQ-022 SHALL pass WAIT and INPACK through a 2-flop synchronizer before use.
REQ-023 SHALL keep STROBE for at least STROBE_CYC clocks; after that, it leaves STROBE on the first clock where synchronized WAIT = 1.
REQ-024 SHALL capture D_IN into rsp_rdata on the last STROBE clock for reads; rsp_rdata is 0 for writes.
REQ-025 SHALL set rsp_inpack = 1 if synchronized INPACK = 0 on any STROBE clock of an I/O read, and 0 otherwise.
REQ-026 SHALL deassert the strobe in HOLD, keep it there HOLD_CYC clocks, then pulse rsp_valid for 1 clock on the HOLD→IDLE transition; DDIR = 0 in IDLE.
REQ-027 SHALL execute a req_space = 11 request as no bus cycle: rsp_valid fires 2 clocks after the handshake, with rsp_timeout = 1.
REQ-028 SHALL never assert two strobes on the same clock, and SHALL never assert any strobe in IDLE or SETUP.
REQ-029 SHALL accept back-to-back requests with at least 1 IDLE clock between cycles.

Reset
REQ-030 SHALL, while RESET = 0 on a rising edge, enter IDLE with: all strobes, CE1, CE2 and REG = 1; DDIR = 0; A = 0; D_OUT = 0; req_ready = 0; rsp_valid = 0; rsp_* = 0; counters and synchronizers = 1/idle.
REQ-031 SHALL abort a reset asserted mid-cycle immediately, with no rsp_valid; req_ready = 1 on the first clock after RESET returns to 1.

Configuration
REQ-032 SHALL, with macro PCC_HOST_TIMEOUT_EN defined, count WAIT-extension clocks; on reaching TIMEOUT_CYC it forces STROBE→HOLD with rsp_timeout = 1 and rsp_rdata = 0xFF.
REQ-033 SHALL, with PCC_HOST_TIMEOUT_EN undefined, wait indefinitely on WAIT, with rsp_timeout driven 1 only for req_space = 11.

Verification
REQ-034 SHALL pass: a memory write with addr 0x0123, data 0xA5, WAIT = 1 → WE low exactly 8 clocks, A = 0x0123, D_OUT = 0xA5 and DDIR = 1 from SETUP through HOLD, rsp_valid 14 clocks after the handshake.
REQ-035 SHALL pass: an attribute read of addr 0x0000 with the card driving 0x41 → REG = 0 and OE low 8 clocks, rsp_rdata = 0x41, rsp_timeout = 0.
REQ-036 SHALL pass: an I/O read of 0x01F7 with WAIT low for 20 clocks from strobe start and INPACK = 0 → IORD extended past 8 clocks until 2 clocks after WAIT rises, rsp_inpack = 1.
REQ-037 SHALL pass, with PCC_HOST_TIMEOUT_EN defined and TIMEOUT_CYC = 16: an I/O write with WAIT held low → IOWR released after 8 + 16 clocks, rsp_timeout = 1.
REQ-038 SHALL pass: RESET = 0 asserted at the third STROBE clock → all strobes = 1 next clock, no rsp_valid, and a subsequent request completes normally.
REQ-039 SHALL pass: two back-to-back requests with req_valid held high → strobes of the two cycles never overlap, and at least 1 IDLE clock with CE1 = 1 separates the cycles.
